// File: rtl/instr_encoder_pkg.sv
// Shared field constants, request type and the field-packing helper for the
// RV64 I/S/B/J instruction encoder.
package instr_enc_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // addi x0, x0, 0 -- emitted in place of any request whose immediate cannot be encoded
    localparam logic [31:0] ENC_NOP = 32'h0000_0013;

    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef struct packed {
        logic [1:0]  imm_src;
        logic [63:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } enc_req_t;

    // Scatter the immediate into the format's bit positions; B/J drop imm[0]
    function automatic logic [31:0] pack_instr(input enc_req_t req);
        logic [31:0] word;
        word = ENC_NOP;
        case (req.imm_src)
            IMM_I: word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            IMM_S: word = {req.imm[11:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:0], req.opcode};
            IMM_B: word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                           req.imm[4:1], req.imm[11], req.opcode};
            IMM_J: word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                           req.rd, req.opcode};
            default: word = ENC_NOP;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_encoder_imm_range_chk.sv
// Combinational range/alignment check: is imm representable in the chosen format?
module imm_range_chk
    import instr_enc_pkg::*;
(
    input  logic [63:0] imm,
    input  logic [1:0]  imm_src,
    output logic        ok
);

    logic fits_12;
    logic fits_13;
    logic fits_21;

    // An N-bit signed field fits when every bit above the sign bit replicates it
    assign fits_12 = (imm[63:11] == {53{imm[11]}});
    assign fits_13 = (imm[63:12] == {52{imm[12]}});
    assign fits_21 = (imm[63:20] == {44{imm[20]}});

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
        ok = 1'b0;
        case (imm_src)
            IMM_I, IMM_S: ok = fits_12;
            IMM_B:        ok = fits_13 && !imm[0];
            IMM_J:        ok = fits_21 && !imm[0];
            default:      ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready encoder: S1 checks and packs the request, S2 is the
// output register. Delivery counters live here.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       imm_src,
    input  logic [63:0]      imm,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    enc_req_t req;
    logic     imm_ok;

    logic s2_ready;
    logic s1_ready;
    logic deliver;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_instr_q, s1_instr_d;
    logic        s1_err_q,   s1_err_d;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q,   out_err_d;

    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign req = '{imm_src: imm_src, imm: imm, opcode: opcode, rd: rd,
                   rs1: rs1, rs2: rs2, funct3: funct3};

    imm_range_chk u_range_chk (
        .imm     (imm),
        .imm_src (imm_src),
        .ok      (imm_ok)
    );

    // A stage may load when it is empty or its contents leave this cycle
    assign deliver  = out_valid_q && out_ready;
    assign s2_ready = !out_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        enc_cnt_d   = enc_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_instr_d = imm_ok ? pack_instr(req) : ENC_NOP;
                s1_err_d   = !imm_ok;
            end
        end

        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_instr_d = s1_instr_q;
                out_err_d   = s1_err_q;
            end
        end

        if (deliver && (enc_cnt_q != CNT_MAX)) begin
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
        end
        if (deliver && out_err_q && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset too, so out_instr reads 0 after reset rather than stale data.
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            enc_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values of the others.
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            enc_cnt_q   <= enc_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign enc_count = enc_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, backpressure, reset
// flush and randomized traffic against an arithmetic reference model.
module tb_instr_encoder;
    import instr_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  imm_src;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm       (imm),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        bit          legal;
        logic [1:0]  src;
        logic [63:0] imm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mdl_enc  = 0;
    int   mdl_err  = 0;
    int   bp_mode  = 0;   // 0: always ready, 1: never ready, 2: random

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic [1:0] src, input logic [63:0] v);
        longint s;
        s = $signed(v);
        case (src)
            2'd0, 2'd1: return (s >= -2048) && (s <= 2047);
            2'd2:       return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            default:    return (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
        endcase
    endfunction

    function automatic longint unsigned fld(input logic [63:0] v, input int hi, input int lo);
        return (v >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
    endfunction

    function automatic logic [31:0] ref_pack(input enc_req_t r);
        longint unsigned w;
        longint unsigned regs;
        if (!ref_legal(r.imm_src, r.imm)) return 32'h0000_0013;
        regs = (longint'(r.rs1) << 15) | (longint'(r.funct3) << 12) | longint'(r.opcode);
        case (r.imm_src)
            2'd0: w = (fld(r.imm, 11, 0) << 20) | regs | (longint'(r.rd) << 7);
            2'd1: w = (fld(r.imm, 11, 5) << 25) | (longint'(r.rs2) << 20) | regs
                      | (fld(r.imm, 4, 0) << 7);
            2'd2: w = (fld(r.imm, 12, 12) << 31) | (fld(r.imm, 10, 5) << 25)
                      | (longint'(r.rs2) << 20) | regs
                      | (fld(r.imm, 4, 1) << 8) | (fld(r.imm, 11, 11) << 7);
            default: w = (fld(r.imm, 20, 20) << 31) | (fld(r.imm, 10, 1) << 21)
                      | (fld(r.imm, 11, 11) << 20) | (fld(r.imm, 19, 12) << 12)
                      | (longint'(r.rd) << 7) | longint'(r.opcode);
        endcase
        return w[31:0];
    endfunction

    function automatic longint sext(input longint unsigned v, input int n);
        if (((v >> (n - 1)) & 1) != 0) return longint'(v) - (longint'(1) << n);
        return longint'(v);
    endfunction

    // Decode an instruction's immediate, as the core's decoder would
    function automatic longint ref_decode(input logic [31:0] ins, input logic [1:0] src);
        logic [63:0] x;
        x = {32'd0, ins};
        case (src)
            2'd0: return sext(fld(x, 31, 20), 12);
            2'd1: return sext((fld(x, 31, 25) << 5) | fld(x, 11, 7), 12);
            2'd2: return sext((fld(x, 31, 31) << 12) | (fld(x, 7, 7) << 11)
                              | (fld(x, 30, 25) << 5) | (fld(x, 11, 8) << 1), 13);
            default: return sext((fld(x, 31, 31) << 20) | (fld(x, 19, 12) << 12)
                                 | (fld(x, 20, 20) << 11) | (fld(x, 30, 21) << 1), 21);
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic enc_req_t mk_req(input logic [1:0] src, input longint v,
                                        input logic [6:0] opc, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [2:0] f3);
        enc_req_t r;
        r.imm_src = src;
        r.imm     = v;
        r.opcode  = opc;
        r.rd      = d;
        r.rs1     = s1;
        r.rs2     = s2;
        r.funct3  = f3;
        return r;
    endfunction

    function automatic logic [63:0] rand_imm();
        longint bnd [16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                             4095, -1048576, 1048574, 1048576, -1048578, 0, 1, -1};
        longint t;
        int     v;
        case ($urandom_range(0, 3))
            0: t = longint'($urandom_range(0, 10000)) - 5000;
            1: t = bnd[$urandom_range(0, 15)];
            2: begin v = $urandom; t = longint'(v >>> 10); end
            default: t = {$urandom, $urandom};
        endcase
        return t;
    endfunction

    task automatic send(input enc_req_t r, input bit has_exp,
                        input logic [31:0] e_instr, input logic e_err);
        exp_t e;
        bit   done;
        done = 1'b0;
        @(negedge clk);
        imm_src  = r.imm_src;
        imm      = r.imm;
        opcode   = r.opcode;
        rd       = r.rd;
        rs1      = r.rs1;
        rs2      = r.rs2;
        funct3   = r.funct3;
        in_valid = 1'b1;
        for (int k = 0; k < 300 && !done; k++) begin
            #1;
            if (in_ready) begin
                e.legal = ref_legal(r.imm_src, r.imm);
                e.instr = has_exp ? e_instr : ref_pack(r);
                e.err   = has_exp ? e_err : !e.legal;
                e.src   = r.imm_src;
                e.imm   = r.imm;
                q.push_back(e);
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", 64'(done), 64'(1));
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("drain_queue", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string nm);
        check({nm, "_enc_count"}, 64'(enc_count), 64'(mdl_enc));
        check({nm, "_err_count"}, 64'(err_count), 64'(mdl_err));
    endtask

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                q.delete();
                mdl_enc = 0;
                mdl_err = 0;
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h with nothing outstanding (t=%0t)",
                             out_instr, $time);
                end else begin
                    e = q.pop_front();
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                    check("out_err", 64'(out_err), 64'(e.err));
                    if (e.legal)
                        check("round_trip", 64'(ref_decode(out_instr, e.src)), e.imm);
                end
                if (mdl_enc < 65535) mdl_enc++;
                if (out_err && mdl_err < 65535) mdl_err++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        enc_req_t r;
        rst      = 1'b1;
        in_valid = 1'b0;
        imm_src  = '0;
        imm      = '0;
        opcode   = '0;
        rd       = '0;
        rs1      = '0;
        rs2      = '0;
        funct3   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check_counters("rst");

        // 1: I-type, with latency check
        send(mk_req(IMM_I, -1, OPC_OP_IMM, 5, 6, 0, 0), 1'b1, 32'hFFF3_0293, 1'b0);
        @(negedge clk); #1;
        check("lat_not_yet", 64'(out_valid), 64'(0));
        @(negedge clk); #1;
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_instr", 64'(out_instr), 64'hFFF3_0293);
        drain();

        // 2: S-type and an out-of-range I
        send(mk_req(IMM_S, 8, OPC_STORE, 0, 2, 7, 2), 1'b1, 32'h0071_2423, 1'b0);
        send(mk_req(IMM_I, 2048, OPC_OP_IMM, 3, 4, 0, 0), 1'b1, 32'h0000_0013, 1'b1);
        // 3: B-type
        send(mk_req(IMM_B, -4, OPC_BRANCH, 0, 1, 2, 0), 1'b1, 32'hFE20_8EE3, 1'b0);
        send(mk_req(IMM_B, 6, OPC_BRANCH, 0, 3, 4, 1), 1'b0, '0, 1'b0);
        send(mk_req(IMM_B, 4097, OPC_BRANCH, 0, 3, 4, 1), 1'b1, 32'h0000_0013, 1'b1);
        drain();
        check_counters("t3");

        // 4: J-type, misaligned then legal
        send(mk_req(IMM_J, 3, OPC_JAL, 1, 0, 0, 0), 1'b1, 32'h0000_0013, 1'b1);
        drain();
        check_counters("t4a");
        send(mk_req(IMM_J, -2048, OPC_JAL, 1, 0, 0, 0), 1'b1, 32'h801F_F0EF, 1'b0);
        drain();
        check_counters("t4b");

        // 5: backpressure
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(mk_req(IMM_S, 8, OPC_STORE, 0, 2, 7, 2), 1'b1, 32'h0071_2423, 1'b0);
        send(mk_req(IMM_I, 2048, OPC_OP_IMM, 3, 4, 0, 0), 1'b1, 32'h0000_0013, 1'b1);
        @(negedge clk);
        imm_src  = IMM_J;
        imm      = -2048;
        opcode   = OPC_JAL;
        rd       = 1;
        in_valid = 1'b1;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("bp_hold_instr", 64'(out_instr), 64'h0071_2423);
            check("bp_hold_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        bp_mode  = 0;
        send(mk_req(IMM_J, -2048, OPC_JAL, 1, 0, 0, 0), 1'b1, 32'h801F_F0EF, 1'b0);
        drain();
        check_counters("t5");

        // 6: reset with two words in flight
        bp_mode = 1;
        repeat (2) @(negedge clk);
        send(mk_req(IMM_I, 100, OPC_OP_IMM, 1, 2, 0, 0), 1'b0, '0, 1'b0);
        send(mk_req(IMM_S, -8, OPC_STORE, 0, 3, 4, 3), 1'b0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst6_out_valid", 64'(out_valid), 64'(0));
        check("rst6_enc_count", 64'(enc_count), 64'(0));
        check("rst6_err_count", 64'(err_count), 64'(0));
        check("rst6_in_ready", 64'(in_ready), 64'(1));
        bp_mode = 0;
        repeat (6) @(negedge clk);
        check_counters("t6");

        // Randomized traffic under random backpressure
        bp_mode = 2;
        for (int n = 0; n < 300; n++) begin
            r = mk_req(2'($urandom_range(0, 3)), rand_imm(), 7'($urandom),
                       5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
            send(r, 1'b0, '0, 1'b0);
            if ($urandom_range(0, 5) == 0) @(negedge clk);
        end
        bp_mode = 0;
        drain();
        check_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
